// File: rtl/riscv_mc_control_pkg.sv
// Shared definitions for the multi-cycle RV32I/RV64I control FSM:
// opcodes, state encoding and immediate helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, PCUPD, TRAP
  } state_e;

  // Callers keep the low XLEN bits, so one helper serves RV32 and RV64.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                       OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  endfunction

endpackage

// File: rtl/riscv_mc_control_if.sv
// Bundle between the control FSM and the instruction memory, register file,
// datapath and data memory. The control side uses the master modport.
interface riscv_mc_control_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              inst_valid;
  logic [31:0]       inst;
  logic              inst_ready;
  logic [XLEN-1:0]   wr_pc;
  logic              br_taken;
  logic              mem_ready;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              rs1_rd;
  logic              rs2_rd;
  logic [REG_AW-1:0] rd_addr;
  logic              rd_wr;
  logic [6:0]        dp_op;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm;
  logic              mem_req;
  logic [XLEN-1:0]   pc;
  logic              illegal;

  modport master (
    input  inst_valid, inst, wr_pc, br_taken, mem_ready,
    output inst_ready, rs1_addr, rs2_addr, rs1_rd, rs2_rd, rd_addr, rd_wr,
           dp_op, funct3, funct7, imm, mem_req, pc, illegal
  );

  modport slave (
    output inst_valid, inst, wr_pc, br_taken, mem_ready,
    input  inst_ready, rs1_addr, rs2_addr, rs1_rd, rs2_rd, rd_addr, rd_wr,
           dp_op, funct3, funct7, imm, mem_req, pc, illegal
  );
endinterface

// File: rtl/riscv_imm_gen.sv
// Combinational RISC-V immediate decoder (I/S/B/U/J), sign-extended from
// inst[31] to XLEN. Formats without an immediate yield zero.
module riscv_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:
        imm32 = {inst[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:
        imm32 = '0;
    endcase
    imm = XLEN'(sext32(imm32));
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> PCUPD,
// visiting only the states an instruction needs; illegal opcodes go via TRAP.
module riscv_mc_control
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              REG_AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  riscv_mc_control_if.master bus
);

  state_e          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc, imm_w;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       legal, use_rs1, use_rs2, has_f3, has_f7;

  assign opc     = inst_q[6:0];
  assign f3      = inst_q[14:12];
  assign legal   = is_legal(opc);
  assign use_rs1 = opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  assign use_rs2 = opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  assign has_f3  = legal && !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  // funct7 only carries meaning for OP and for the shift forms of OP_IMM.
  assign has_f7  = (opc == OPC_OP) || (opc == OPC_OP_IMM && f3[1:0] == 2'b01);
  assign pc_inc  = pc_q + XLEN'(4);

  riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_q),
    .imm  (imm_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      inst_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    pc_d           = pc_q;
    bus.inst_ready = 1'b0;
    bus.rs1_addr   = REG_AW'(inst_q[19:15]);
    bus.rs2_addr   = REG_AW'(inst_q[24:20]);
    bus.rs1_rd     = 1'b0;
    bus.rs2_rd     = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_wr      = 1'b0;
    bus.dp_op      = '0;
    bus.funct3     = '0;
    bus.funct7     = '0;
    bus.imm        = '0;
    bus.mem_req    = 1'b0;
    bus.illegal    = 1'b0;

    // Datapath controls stay stable for the whole instruction, idle in FETCH.
    if (state_q != FETCH) begin
      bus.dp_op  = legal  ? opc : 7'd0;
      bus.funct3 = has_f3 ? f3 : 3'd0;
      bus.funct7 = has_f7 ? inst_q[31:25] : 7'd0;
      bus.imm    = imm_w;
    end

    case (state_q)
      FETCH: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) begin
          inst_d  = bus.inst;
          state_d = DECODE;
        end
      end
      DECODE: begin
        bus.rs1_rd = use_rs1;
        bus.rs2_rd = use_rs2;
        state_d    = legal ? EXEC : TRAP;
      end
      EXEC: begin
        if (opc == OPC_LOAD || opc == OPC_STORE) state_d = MEM;
        else if (opc == OPC_BRANCH)               state_d = PCUPD;
        else                                      state_d = WB;
      end
      MEM: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) state_d = (opc == OPC_LOAD) ? WB : PCUPD;
      end
      WB: begin
        bus.rd_addr = REG_AW'(inst_q[11:7]);
        bus.rd_wr   = (inst_q[11:7] != 5'd0);
        state_d     = PCUPD;
      end
      PCUPD: begin
        case (opc)
          OPC_JAL:    pc_d = bus.wr_pc;
          OPC_JALR:   pc_d = {bus.wr_pc[XLEN-1:1], 1'b0};
          OPC_BRANCH: pc_d = bus.br_taken ? bus.wr_pc : pc_inc;
          default:    pc_d = pc_inc;
        endcase
        state_d = FETCH;
      end
      // The trap cycle carries the illegal pulse; the pc+4 step happens in
      // PCUPD, giving the three-edge trap latency.
      TRAP: begin
        bus.illegal = 1'b1;
        state_d     = PCUPD;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Randomized bench for riscv_mc_control: a latency-table model predicts every
// output on every cycle; directed instructions pin the model with literals.
module tb_riscv_mc_control;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst64 = 1'b1;
  always #5 clk = ~clk;

  riscv_mc_control_if #(.XLEN(32), .REG_AW(5)) bus ();
  riscv_mc_control_if #(.XLEN(64), .REG_AW(5)) bus64 ();

  riscv_mc_control #(.XLEN(32), .RESET_PC(32'h0), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  riscv_mc_control #(.XLEN(64), .RESET_PC(64'h0), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst64), .bus(bus64));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit legal_m(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic bit writes_m(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  endfunction

  // Edges from accept to pc update.
  function automatic int lat_m(input logic [31:0] in, input int w);
    case (in[6:0])
      7'h63:   return 3;
      7'h23:   return 4 + w;
      7'h03:   return 5 + w;
      default: return legal_m(in[6:0]) ? 4 : 3;
    endcase
  endfunction

  function automatic logic [31:0] imm_m(input logic [31:0] in);
    int s, sg, r;
    s  = $signed(in);
    sg = s >>> 31;
    r  = 0;
    case (in[6:0])
      7'h37, 7'h17:        r = s & 32'hFFFFF000;
      7'h67, 7'h03, 7'h13: r = s >>> 20;
      7'h23:               r = (s >>> 25) * 32 + int'(in[11:7]);
      7'h63:               r = sg * 4096 + int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2;
      7'h6F:               r = sg * 1048576 + int'(in[19:12]) * 4096 + int'(in[20]) * 2048 + int'(in[30:21]) * 2;
      default:             r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] npc_m(input logic [31:0] in, input logic [31:0] pc,
                                        input logic [31:0] wpc, input logic br);
    case (in[6:0])
      7'h6F:   return wpc;
      7'h67:   return wpc & 32'hFFFFFFFE;
      7'h63:   return br ? wpc : pc + 32'd4;
      default: return pc + 32'd4;
    endcase
  endfunction

  logic        m_on  = 1'b0;
  int          m_k   = -1;
  int          m_L   = 0;
  int          m_W   = 0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc  = '0;
  logic [31:0] m_pc0 = '0;
  logic [31:0] m_npc = '0;

  int          mreq_cnt = 0, rdwr_cnt = 0, ill_cnt = 0, lat_obs = -1;
  logic [31:0] imm_seen = '0;
  logic [4:0]  rd_seen  = '0;

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [6:0] op;
    logic [2:0] f3;
    bit lg, ldst, exp_r1, exp_r2, exp_wr;
    #1;
    if (rst) begin
      m_on = 1'b0;
      m_pc = 32'h0;
    end else if (m_on) m_k++;
    if (m_on && m_k == m_L) begin
      m_pc = m_npc;
      m_on = 1'b0;
    end

    if (bus.mem_req) mreq_cnt++;
    if (bus.illegal) ill_cnt++;
    if (bus.rd_wr) begin rdwr_cnt++; rd_seen = bus.rd_addr; end
    if (lat_obs < 0 && bus.pc !== m_pc0) lat_obs = m_k;
    if (m_on && m_k == 0) imm_seen = bus.imm;

    op   = m_inst[6:0];
    f3   = m_inst[14:12];
    lg   = legal_m(op);
    ldst = (op == 7'h03 || op == 7'h23);
    if (!m_on) begin
      chk("idle inst_ready", bus.inst_ready, 1);
      chk("idle dp_op", bus.dp_op, 0);
      chk("idle funct3", bus.funct3, 0);
      chk("idle funct7", bus.funct7, 0);
      chk("idle imm", bus.imm, 0);
      chk("idle rs_rd", {bus.rs1_rd, bus.rs2_rd}, 0);
      chk("idle rd_wr", bus.rd_wr, 0);
      chk("idle mem_req", bus.mem_req, 0);
      chk("idle illegal", bus.illegal, 0);
    end else begin
      exp_r1 = (m_k == 0) && (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
      exp_r2 = (m_k == 0) && (op inside {7'h63, 7'h23, 7'h33});
      exp_wr = writes_m(op) && (m_k == m_L - 2) && (m_inst[11:7] != 5'd0);
      chk("busy inst_ready", bus.inst_ready, 0);
      chk("dp_op", bus.dp_op, lg ? op : 7'd0);
      chk("funct3", bus.funct3, (lg && !(op inside {7'h37, 7'h17, 7'h6F})) ? f3 : 3'd0);
      chk("funct7", bus.funct7,
          (op == 7'h33 || (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))) ? m_inst[31:25] : 7'd0);
      chk("imm", bus.imm, imm_m(m_inst));
      chk("rs1_rd", bus.rs1_rd, exp_r1);
      chk("rs2_rd", bus.rs2_rd, exp_r2);
      if (exp_r1) chk("rs1_addr", bus.rs1_addr, m_inst[19:15]);
      if (exp_r2) chk("rs2_addr", bus.rs2_addr, m_inst[24:20]);
      chk("rd_wr", bus.rd_wr, exp_wr);
      if (exp_wr) chk("rd_addr", bus.rd_addr, m_inst[11:7]);
      chk("mem_req", bus.mem_req, ldst && m_k >= 2 && m_k <= 2 + m_W);
      chk("illegal", bus.illegal, !lg && m_k == 1);
    end
    chk("pc", bus.pc, m_pc);
  end

  // ---------------- driver ----------------
  // Runs one instruction: w wait cycles before mem_ready, optional reset when
  // the model reaches cycle abort_k. Returns on a negedge in FETCH.
  task automatic issue(input logic [31:0] in, input int w, input logic [31:0] wpc,
                       input logic br, input int idle, input int abort_k);
    int  guard;
    bit  ldst;
    ldst = (in[6:0] == 7'h03 || in[6:0] == 7'h23);
    repeat (idle) begin
      bus.inst_valid = 1'b0;
      bus.inst       = $urandom;
      bus.mem_ready  = 1'($urandom);
      @(negedge clk);
    end
    bus.inst       = in;
    bus.inst_valid = 1'b1;
    bus.wr_pc      = wpc;
    bus.br_taken   = br;
    bus.mem_ready  = 1'($urandom);
    m_inst = in;  m_W = w;  m_L = lat_m(in, w);
    m_pc0  = m_pc;
    m_npc  = npc_m(in, m_pc, wpc, br);
    m_k    = -1;  m_on = 1'b1;
    mreq_cnt = 0; rdwr_cnt = 0; ill_cnt = 0; lat_obs = -1; rd_seen = '0;
    guard  = 0;
    forever begin
      @(negedge clk);
      if (!m_on) break;
      guard++;
      if (guard > 300) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: instruction %h still busy after %0d cycles", in, guard);
        m_on = 1'b0;
        break;
      end
      if (abort_k >= 0 && m_k == abort_k) rst = 1'b1;
      bus.inst_valid = 1'($urandom);
      bus.inst       = $urandom;
      if (ldst && m_k >= 2 && m_k <= 1 + w) bus.mem_ready = 1'b0;
      else if (ldst && m_k == 2 + w)        bus.mem_ready = 1'b1;
      else                                  bus.mem_ready = 1'($urandom);
    end
    rst            = 1'b0;
    bus.inst_valid = 1'b0;
  endtask

  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int n, wr64;
    bus.inst_valid = 0; bus.inst = '0; bus.wr_pc = '0; bus.br_taken = 0; bus.mem_ready = 0;
    bus64.inst_valid = 0; bus64.inst = '0; bus64.wr_pc = '0; bus64.br_taken = 0; bus64.mem_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset pc", bus.pc, 32'h0);
    chk("reset inst_ready", bus.inst_ready, 1);

    // ADDI x5,x1,-3 presented right after reset
    issue(32'hFFD08293, 0, $urandom, 1'b0, 0, -1);
    chk("addi imm", imm_seen, 32'hFFFFFFFD);
    chk("addi rd", rd_seen, 5);
    chk("addi rd_wr count", rdwr_cnt, 1);
    chk("addi latency", lat_obs, 4);
    chk("addi pc", bus.pc, 32'h4);

    // BEQ x1,x2 taken / not taken from pc 0x100
    issue(32'h0000006F, 0, 32'h100, 1'b0, 1, -1);
    chk("jal x0 pc", bus.pc, 32'h100);
    chk("jal x0 no write", rdwr_cnt, 0);
    issue(32'h00208063, 0, 32'h80, 1'b1, 0, -1);
    chk("beq taken pc", bus.pc, 32'h80);
    chk("beq taken latency", lat_obs, 3);
    chk("beq taken no write", rdwr_cnt, 0);
    issue(32'h0000006F, 0, 32'h100, 1'b0, 0, -1);
    issue(32'h00208063, 0, 32'h80, 1'b0, 2, -1);
    chk("beq not taken pc", bus.pc, 32'h104);
    chk("beq not taken no write", rdwr_cnt, 0);

    // LW x7 with three wait cycles
    issue(32'h0000A383, 3, $urandom, 1'b0, 0, -1);
    chk("lw mem_req cycles", mreq_cnt, 4);
    chk("lw latency", lat_obs, 8);
    chk("lw rd", rd_seen, 7);
    chk("lw rd_wr count", rdwr_cnt, 1);
    chk("lw pc", bus.pc, 32'h108);

    // ADDI x0,x0,1: no write-back
    issue(32'h00100013, 0, $urandom, 1'b0, 0, -1);
    chk("addi x0 rd_wr count", rdwr_cnt, 0);
    chk("addi x0 pc", bus.pc, 32'h10C);

    // Illegal opcode, then a normal instruction
    issue(32'h0000007F, 0, $urandom, 1'b0, 0, -1);
    chk("illegal pulses", ill_cnt, 1);
    chk("illegal no mem_req", mreq_cnt, 0);
    chk("illegal no write", rdwr_cnt, 0);
    chk("illegal latency", lat_obs, 3);
    chk("illegal pc", bus.pc, 32'h110);
    issue(32'h00500093, 0, $urandom, 1'b0, 0, -1);
    chk("after illegal rd", rd_seen, 1);
    chk("after illegal pc", bus.pc, 32'h114);

    // pc wraps modulo 2^32
    issue(32'h0000006F, 0, 32'hFFFFFFFC, 1'b0, 0, -1);
    issue(32'h00100013, 0, $urandom, 1'b0, 0, -1);
    chk("pc wrap", bus.pc, 32'h0);

    // Reset during a memory wait
    issue(32'h0000006F, 0, 32'h200, 1'b0, 0, -1);
    issue(32'h0000A383, 10, $urandom, 1'b0, 0, 5);
    chk("abort pc", bus.pc, 32'h0);
    chk("abort mem_req", bus.mem_req, 0);
    chk("abort inst_ready", bus.inst_ready, 1);
    issue(32'hFFD08293, 0, $urandom, 1'b0, 1, -1);
    chk("after abort pc", bus.pc, 32'h4);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom); while (legal_m(op));
      end else op = ops[$urandom_range(0, 8)];
      issue({r[31:7], op}, $urandom_range(0, 4), $urandom, 1'($urandom),
            $urandom_range(0, 2), -1);
    end

    // RV64: JALR x1,-1(x2) with an all-ones target
    @(negedge clk);
    rst64 = 1'b0;
    @(negedge clk);
    chk("rv64 reset pc", bus64.pc, 64'h0);
    chk("rv64 inst_ready", bus64.inst_ready, 1);
    bus64.inst       = 32'hFFF100E7;
    bus64.wr_pc      = 64'hFFFF_FFFF_FFFF_FFFF;
    bus64.inst_valid = 1'b1;
    @(negedge clk);
    bus64.inst_valid = 1'b0;
    chk("rv64 jalr imm", bus64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    n = 0; wr64 = 0;
    while (bus64.pc == 64'h0 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus64.rd_wr) wr64++;
    end
    chk("rv64 jalr latency", n, 4);
    chk("rv64 jalr pc", bus64.pc, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("rv64 jalr rd_wr count", wr64, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
